sal_ref_ctrl: RTL and testbench

Per-bank auto-refresh scheduler. It sits directly upstream of the bank controller and drives that block's ref_req_i / ref_gnt_o handshake. It generates a refresh obligation every tREFI and postpones refreshes while traffic is pending, up to a credit limit. At the limit it raises an urgency flag so the request path stalls and the bank drains to closed.

---
 rtl/sal_ddr_pkg.sv | 13 +
 rtl/sal_refi_tick.sv | 25 ++
 rtl/sal_ref_ctrl.sv | 89 ++++++++
 tb/tb_sal_ref_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sal_ddr_pkg.sv
// Shared DDR controller types: refresh scheduler state encoding and default widths.
package sal_ddr_pkg;

    localparam int DEF_REFI_WIDTH   = 16;
    localparam int DEF_CREDIT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } ref_state_e;

endpackage

// File: rtl/sal_refi_tick.sv
// Reloadable tREFI down-counter: one-cycle tick at zero, reload on the same edge, hold while disabled.
module sal_refi_tick #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] reload_val,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q;

    assign tick = en & (cnt_q == '0);

    // reload_val is only sampled at zero, so a new interval applies from the next reload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= reload_val;
        end else if (en) begin
            cnt_q <= (cnt_q == '0) ? reload_val : cnt_q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/sal_ref_ctrl.sv
// Per-bank auto-refresh scheduler: tREFI credits, postponement under traffic, urgency at threshold.
module sal_ref_ctrl
    import sal_ddr_pkg::*;
#(
    parameter int REFI_WIDTH   = DEF_REFI_WIDTH,
    parameter int CREDIT_WIDTH = DEF_CREDIT_WIDTH,
    parameter int MAX_POSTPONE = 8,
    parameter int URGENT_TH    = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ref_en_i,
    input  logic [REFI_WIDTH-1:0]   t_refi_m1_i,
    input  logic                    req_valid_i,
    input  logic                    ref_gnt_i,
    output logic                    ref_req_o,
    output logic                    ref_urgent_o,
    output logic [CREDIT_WIDTH-1:0] pending_o,
    output logic                    overflow_o
);

    localparam logic [CREDIT_WIDTH-1:0] MAX_P = CREDIT_WIDTH'(MAX_POSTPONE);
    localparam logic [CREDIT_WIDTH-1:0] URG_P = CREDIT_WIDTH'(URGENT_TH);

    ref_state_e              state_q, state_d;
    logic [CREDIT_WIDTH-1:0] pending_q;
    logic                    overflow_q;
    logic                    tick;
    logic                    dec;
    logic                    at_urgent;

    sal_refi_tick #(.WIDTH(REFI_WIDTH)) u_refi_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (ref_en_i),
        .reload_val (t_refi_m1_i),
        .tick       (tick)
    );

    assign dec       = (state_q == S_REQ) & ref_gnt_i;
    assign at_urgent = (pending_q >= URG_P);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // A tick at the credit ceiling is lost; flag it until reset
            if (tick && !dec) begin
                if (pending_q == MAX_P) begin
                    overflow_q <= 1'b1;
                end else begin
                    pending_q <= pending_q + CREDIT_WIDTH'(1);
                end
            end else if (!tick && dec) begin
                pending_q <= pending_q - CREDIT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ref_en_i && (pending_q != '0) && (!req_valid_i || at_urgent)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Disable withdraws the request even without a grant
                if (!ref_en_i) begin
                    state_d = S_IDLE;
                end else if (ref_gnt_i) begin
                    state_d = S_GAP;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ref_req_o    = (state_q == S_REQ);
    assign ref_urgent_o = ref_en_i & at_urgent;
    assign pending_o    = pending_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Directed bench for sal_ref_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_sal_ref_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ref_en;
    logic [15:0] t_refi_m1;
    logic        req_valid;
    logic        ref_gnt;
    logic        ref_req;
    logic        ref_urgent;
    logic [3:0]  pending;
    logic        overflow;

    logic gnt_tie;
    logic gnt_force;

    int n_cmp = 0;
    int n_bad = 0;

    assign ref_gnt = gnt_tie ? ref_req : gnt_force;

    always #5 clk = ~clk;

    sal_ref_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ref_en_i     (ref_en),
        .t_refi_m1_i  (t_refi_m1),
        .req_valid_i  (req_valid),
        .ref_gnt_i    (ref_gnt),
        .ref_req_o    (ref_req),
        .ref_urgent_o (ref_urgent),
        .pending_o    (pending),
        .overflow_o   (overflow)
    );

    // A grant while nothing is outstanding would underflow the credit counter
    always @(posedge clk) begin
        if (rst_n && ref_req && ref_gnt && pending == 4'd0) begin
            n_bad++;
            $display("FAIL gnt_at_zero: grant accepted with pending=%0d, required pending>0", pending);
        end
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] refi;
        logic        rv;
        logic        tie;
        logic        gf;
        int          run;
        logic        req;
        logic        urg;
        logic [3:0]  pend;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic en, logic [15:0] refi, logic rv, logic tie,
                                logic gf, int run, logic req, logic urg, logic [3:0] pend,
                                logic ovf);
        vec_t v;
        v.rst = rst; v.en = en; v.refi = refi; v.rv = rv; v.tie = tie; v.gf = gf;
        v.run = run; v.req = req; v.urg = urg; v.pend = pend; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic er, input logic eu,
                         input logic [3:0] ep, input logic eo);
        logic [6:0] act;
        logic [6:0] exp;
        act = {ref_req, ref_urgent, pending, overflow};
        exp = {er, eu, ep, eo};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got req=%b urg=%b pend=%0d ovf=%b, required req=%b urg=%b pend=%0d ovf=%b",
                     name, act[6], act[5], act[4:1], act[0], er, eu, ep, eo);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts and ends on a negedge; the returned half-cycle is cycle 0 after reset release
    task automatic do_reset(input logic [15:0] refi, input logic en, input logic rv,
                            input logic tie, input logic gf);
        rst_n     = 1'b0;
        t_refi_m1 = refi;
        ref_en    = en;
        req_valid = rv;
        gnt_tie   = tie;
        gnt_force = gf;
        adv(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ref_en = 1'b0; t_refi_m1 = 16'd0; req_valid = 1'b0;
        gnt_tie = 1'b0; gnt_force = 1'b0;
        @(negedge clk);

        // Basic tick: period 10, grant tied to request
        tbl.push_back(mk(1, 1, 16'd9, 0, 1, 0, 0, 0, 0, 4'd0, 0));
        tbl.push_back(mk(0, 1, 16'd9, 0, 1, 0, 10, 0, 0, 4'd1, 0));
        tbl.push_back(mk(0, 1, 16'd9, 0, 1, 0, 1, 1, 0, 4'd1, 0));
        tbl.push_back(mk(0, 1, 16'd9, 0, 1, 0, 1, 0, 0, 4'd0, 0));
        tbl.push_back(mk(0, 1, 16'd9, 0, 1, 0, 8, 0, 0, 4'd1, 0));
        tbl.push_back(mk(0, 1, 16'd9, 0, 1, 0, 1, 1, 0, 4'd1, 0));
        tbl.push_back(mk(0, 1, 16'd9, 0, 1, 0, 1, 0, 0, 4'd0, 0));
        // Postponement under traffic, then saturation and overflow
        tbl.push_back(mk(1, 1, 16'd4, 1, 0, 0, 0, 0, 0, 4'd0, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 5, 0, 0, 4'd1, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 5, 0, 0, 4'd2, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 15, 0, 0, 4'd5, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 4, 0, 0, 4'd5, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 1, 0, 1, 4'd6, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 1, 1, 1, 4'd6, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 4, 1, 1, 4'd7, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 5, 1, 1, 4'd8, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 4, 1, 1, 4'd8, 0));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 1, 1, 1, 4'd8, 1));
        tbl.push_back(mk(0, 1, 16'd4, 1, 0, 0, 5, 1, 1, 4'd8, 1));
        tbl.push_back(mk(0, 1, 16'd4, 1, 1, 0, 1, 0, 1, 4'd7, 1));
        tbl.push_back(mk(0, 1, 16'd4, 1, 1, 0, 2, 1, 1, 4'd7, 1));

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                do_reset(tbl[i].refi, tbl[i].en, tbl[i].rv, tbl[i].tie, tbl[i].gf);
            end else begin
                ref_en    = tbl[i].en;
                t_refi_m1 = tbl[i].refi;
                req_valid = tbl[i].rv;
                gnt_tie   = tbl[i].tie;
                gnt_force = tbl[i].gf;
                adv(tbl[i].run);
            end
            check($sformatf("vec%0d", i), tbl[i].req, tbl[i].urg, tbl[i].pend, tbl[i].ovf);
        end

        // Grant coinciding with a tick leaves the credit count unchanged
        do_reset(16'd4, 1, 1, 0, 0);
        adv(15); check("sim_pend3", 0, 0, 4'd3, 0);
        req_valid = 1'b0;
        adv(1);  check("sim_req", 1, 0, 4'd3, 0);
        adv(1);  check("sim_hold", 1, 0, 4'd3, 0);
        adv(2);  check("sim_tick_cyc", 1, 0, 4'd3, 0);
        gnt_force = 1'b1;
        adv(1);  check("sim_gap", 0, 0, 4'd3, 0);
        gnt_force = 1'b0;
        adv(1);  check("sim_idle", 0, 0, 4'd3, 0);
        adv(1);  check("sim_rereq", 1, 0, 4'd3, 0);

        // Drain from 7 under traffic; new interval only applies after the pending reload
        do_reset(16'd4, 1, 1, 0, 0);
        adv(30); check("drn_urg", 0, 1, 4'd6, 0);
        t_refi_m1 = 16'd200;
        adv(1);  check("drn_req", 1, 1, 4'd6, 0);
        adv(4);  check("drn_p7", 1, 1, 4'd7, 0);
        gnt_tie = 1'b1;
        adv(1);  check("drn_p6", 0, 1, 4'd6, 0);
        adv(1);  check("drn_idle", 0, 1, 4'd6, 0);
        adv(1);  check("drn_req2", 1, 1, 4'd6, 0);
        adv(1);  check("drn_p5", 0, 0, 4'd5, 0);
        adv(1);  check("drn_stop", 0, 0, 4'd5, 0);
        adv(5);  check("drn_hold", 0, 0, 4'd5, 0);

        // Disable mid-request, re-enable resumes the held count, then reset while in S_REQ
        do_reset(16'd9, 1, 0, 0, 0);
        adv(11); check("dis_req", 1, 0, 4'd1, 0);
        adv(1);  check("dis_req2", 1, 0, 4'd1, 0);
        ref_en = 1'b0;
        adv(1);  check("dis_drop", 0, 0, 4'd1, 0);
        adv(20); check("dis_frozen", 0, 0, 4'd1, 0);
        ref_en = 1'b1;
        adv(1);  check("ena_req", 1, 0, 4'd1, 0);
        adv(6);  check("ena_pre", 1, 0, 4'd1, 0);
        adv(1);  check("ena_tick", 1, 0, 4'd2, 0);
        rst_n = 1'b0;
        t_refi_m1 = 16'd3;
        adv(1);  check("rst_mid", 0, 0, 4'd0, 0);
        rst_n = 1'b1;
        adv(3);  check("rst_pre", 0, 0, 4'd0, 0);
        adv(1);  check("rst_tick", 0, 0, 4'd1, 0);
        adv(1);  check("rst_req", 1, 0, 4'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
